branch_redirect_ctrl: RTL and testbench

Sequencer for branch resolution in the execute stage of the RV64 pipeline. It accepts one conditional branch at a time, evaluates the condition, and compares the outcome against the fetch-stage static prediction. On a mispredict it drives a redirect handshake to fetch, then holds a flush window for the younger pipeline stages. While a redirect or flush is in progress it stalls execute.

---
 rtl/branch_pkg.sv | 25 ++
 rtl/branch_cmp.sv | 35 +++
 rtl/branch_redirect_ctrl.sv | 144 ++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the execute-stage branch redirect controller:
// condition codes, FSM state encoding and flush counter width.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int FLUSH_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } br_state_e;

    // 010/011 are reserved encodings: never taken, never redirect.
    function automatic logic f3_is_branch(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator.
// Reserved funct3 encodings evaluate as not taken.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = !lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Execute-stage branch resolution: mispredict redirect handshake + flush window.
// Optional BRANCH_STATS_EN adds branch / mispredict counters.
module branch_redirect_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_funct3,
    input  logic [XLEN-1:0] br_rs1,
    input  logic [XLEN-1:0] br_rs2,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic            br_pred_taken,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            flush,
`ifdef BRANCH_STATS_EN
    output logic            stall_ex,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`else
    output logic            stall_ex
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT =
        FLUSH_CNT_W'(FLUSH_CYCLES);

    br_state_e              state_q;
    logic [FLUSH_CNT_W-1:0] cnt_q;
    logic                   br_ready_q;
    logic                   redir_valid_q;
    logic                   flush_q;
    logic                   stall_q;
    logic [XLEN-1:0]        redir_pc_q;
    logic [XLEN-1:0]        redir_pc_d;

    logic taken;
    logic accept;
    logic mispred;

    branch_cmp #(
        .XLEN(XLEN)
    ) u_cmp (
        .funct3(br_funct3),
        .rs1   (br_rs1),
        .rs2   (br_rs2),
        .taken (taken)
    );

    assign accept     = br_valid && br_ready_q;
    assign mispred    = f3_is_branch(br_funct3) && (taken != br_pred_taken);
    assign redir_pc_d = taken ? (br_pc + br_imm) : (br_pc + XLEN'(4));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            br_ready_q    <= 1'b1;
            redir_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            stall_q       <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && mispred) begin
                        state_q       <= REDIRECT;
                        redir_valid_q <= 1'b1;
                        redir_pc_q    <= redir_pc_d;
                        stall_q       <= 1'b1;
                        br_ready_q    <= 1'b0;
                    end
                end
                REDIRECT: begin
                    if (redir_ready) begin
                        redir_valid_q <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            state_q    <= IDLE;
                            stall_q    <= 1'b0;
                            br_ready_q <= 1'b1;
                        end else begin
                            state_q <= FLUSH;
                            flush_q <= 1'b1;
                            cnt_q   <= FLUSH_INIT;
                        end
                    end
                end
                FLUSH: begin
                    // Last flush cycle when the counter reaches 1.
                    if (cnt_q <= FLUSH_CNT_W'(1)) begin
                        state_q    <= IDLE;
                        flush_q    <= 1'b0;
                        stall_q    <= 1'b0;
                        br_ready_q <= 1'b1;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q - FLUSH_CNT_W'(1);
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    br_ready_q    <= 1'b1;
                    redir_valid_q <= 1'b0;
                    flush_q       <= 1'b0;
                    stall_q       <= 1'b0;
                end
            endcase
        end
    end

    assign br_ready    = br_ready_q;
    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;
    assign flush       = flush_q;
    assign stall_ex    = stall_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (accept) begin
            stat_br_q <= stat_br_q + 32'd1;
            if (mispred) begin
                stat_mp_q <= stat_mp_q + 32'd1;
            end
        end
    end

    assign stat_branches = stat_br_q;
    assign stat_mispred  = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl (FLUSH_CYCLES = 2).
// Stats checks are active when BRANCH_STATS_EN is defined.
module tb_branch_redirect_ctrl;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            br_valid;
    logic            br_ready;
    logic [2:0]      br_funct3;
    logic [XLEN-1:0] br_rs1;
    logic [XLEN-1:0] br_rs2;
    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] br_imm;
    logic            br_pred_taken;
    logic            redir_valid;
    logic            redir_ready;
    logic [XLEN-1:0] redir_pc;
    logic            flush;
    logic            stall_ex;
`ifdef BRANCH_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispred;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(
        .XLEN        (XLEN),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .br_valid     (br_valid),
        .br_ready     (br_ready),
        .br_funct3    (br_funct3),
        .br_rs1       (br_rs1),
        .br_rs2       (br_rs2),
        .br_pc        (br_pc),
        .br_imm       (br_imm),
        .br_pred_taken(br_pred_taken),
        .redir_valid  (redir_valid),
        .redir_ready  (redir_ready),
        .redir_pc     (redir_pc),
        .flush        (flush),
`ifdef BRANCH_STATS_EN
        .stall_ex     (stall_ex),
        .stat_branches(stat_branches),
        .stat_mispred (stat_mispred)
`else
        .stall_ex     (stall_ex)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] pc,
                         input logic [63:0] imm, input logic pred);
        br_valid      = 1'b1;
        br_funct3     = f3;
        br_rs1        = a;
        br_rs2        = b;
        br_pc         = pc;
        br_imm        = imm;
        br_pred_taken = pred;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] b;
        logic        pred;
    } vec_t;

    vec_t vecs[10];
    int   redirs;

    initial begin
        reset       = 1'b1;
        br_valid    = 1'b0;
        redir_ready = 1'b0;
        drive(3'b000, 0, 0, 0, 0, 1'b0);
        br_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_ready", br_ready, 1);
        check("rst_rvalid", redir_valid, 0);
        check("rst_flush", flush, 0);
        check("rst_stall", stall_ex, 0);
        check("rst_pc", redir_pc, 0);

        // Correct predictions back-to-back, zero bubble.
        drive(3'b000, 5, 5, 64'h100, 64'h20, 1'b1);
        step();
        check("beq_ready", br_ready, 1);
        check("beq_stall", stall_ex, 0);
        check("beq_rvalid", redir_valid, 0);
        drive(3'b001, 1, 2, 64'h104, 64'h20, 1'b1);
        step();
        drive(3'b010, 1, 2, 64'h108, 64'h20, 1'b1);
        step();
        check("b2b_ready", br_ready, 1);
        check("b2b_rvalid", redir_valid, 0);
        check("rsv_stall", stall_ex, 0);

        // blt mispredict, fetch ready immediately.
        redir_ready = 1'b1;
        drive(3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h1000, 64'h40, 1'b0);
        step();
        br_valid = 1'b0;
        check("blt_rvalid", redir_valid, 1);
        check("blt_pc", redir_pc, 64'h1040);
        check("blt_stall", stall_ex, 1);
        check("blt_ready", br_ready, 0);
        check("blt_flush1", flush, 0);
        step();
        check("blt_flush2", flush, 1);
        check("blt_rv_lo", redir_valid, 0);
        step();
        check("blt_flush3", flush, 1);
        check("blt_rdy3", br_ready, 0);
        step();
        check("blt_flush4", flush, 0);
        check("blt_rdy4", br_ready, 1);
        check("blt_stall4", stall_ex, 0);

        // bltu not taken vs pred 1, fetch stalls for 5 cycles.
        redir_ready = 1'b0;
        drive(3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h2000, 64'h80, 1'b1);
        step();
        // A new mispredicting branch while busy must be ignored.
        drive(3'b000, 3, 3, 64'h3000, 64'h10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("hold_rvalid", redir_valid, 1);
            check("hold_pc", redir_pc, 64'h2004);
            check("hold_flush", flush, 0);
            step();
        end
        br_valid = 1'b0;
        check("hold_rvalid6", redir_valid, 1);
        redir_ready = 1'b1;
        step();
        check("bltu_rv_lo", redir_valid, 0);
        check("bltu_flush", flush, 1);
        step();
        step();
        check("bltu_ready", br_ready, 1);
        check("bltu_pc_keep", redir_pc, 64'h2004);

        // Target wraps; reset during flush.
        drive(3'b001, 1, 2, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1'b0);
        step();
        br_valid = 1'b0;
        check("wrap_pc", redir_pc, 64'h4);
        step();
        check("wrap_flush", flush, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstf_flush", flush, 0);
        check("rstf_stall", stall_ex, 0);
        check("rstf_ready", br_ready, 1);
        check("rstf_pc", redir_pc, 0);

        // 10 branches, 3 mispredicts.
        vecs[0] = '{3'b000, 3, 3, 1'b1};
        vecs[1] = '{3'b001, 3, 3, 1'b0};
        vecs[2] = '{3'b100, 64'hFFFF_FFFF_FFFF_FFFB, 2, 1'b0};
        vecs[3] = '{3'b101, 64'hFFFF_FFFF_FFFF_FFFB, 2, 1'b0};
        vecs[4] = '{3'b110, 1, 2, 1'b1};
        vecs[5] = '{3'b111, 1, 2, 1'b1};
        vecs[6] = '{3'b010, 1, 2, 1'b0};
        vecs[7] = '{3'b011, 1, 2, 1'b1};
        vecs[8] = '{3'b101, 7, 7, 1'b1};
        vecs[9] = '{3'b000, 1, 2, 1'b1};
        redirs = 0;
        redir_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].f3, vecs[i].a, vecs[i].b, 64'h4000, 64'h10,
                  vecs[i].pred);
            step();
            br_valid = 1'b0;
            if (redir_valid) redirs++;
            for (int k = 0; k < 10 && !br_ready; k++) step();
            check("loop_ready", br_ready, 1);
        end
        check("loop_redirs", redirs, 3);
`ifdef BRANCH_STATS_EN
        check("stat_br", stat_branches, 10);
        check("stat_mp", stat_mispred, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
